// File: rtl/dpll_loop_ctrl.sv
// Digital PLL loop controller: turns PFD measurements into a saturating DCO
// tuning word and sequences the loop through acquire, track and locked phases.
module dpll_loop_ctrl #(
  parameter int unsigned N_BIT     = 8,
  parameter int unsigned CODE_W    = 10,
  parameter int unsigned CODE_INIT = 512,
  parameter int unsigned ACQ_SHIFT = 0,
  parameter int unsigned TRK_SHIFT = 2,
  parameter int unsigned ACQ_TOL   = 8,
  parameter int unsigned LOCK_TOL  = 2,
  parameter int unsigned LOCK_CNT  = 8,
  parameter int unsigned TO_STEP   = 64
) (
  input  logic              Clock,
  input  logic              nReset,
  input  logic              enable,
  input  logic              pfd_ready,
  input  logic              pfd_timeout,
  input  logic              pfd_first_second,
  input  logic [N_BIT-1:0]  pfd_diff_1,
  input  logic [N_BIT-1:0]  pfd_diff_2,
  output logic [CODE_W-1:0] dco_code,
  output logic              code_valid,
  output logic              locked,
  output logic [1:0]        loop_state,
  output logic [N_BIT:0]    err_out
);

  localparam int unsigned ERR_W = N_BIT + 1;
  localparam int unsigned SUM_W = CODE_W + 2;
  localparam int unsigned CNT_W = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_TRACK   = 2'd2,
    ST_LOCKED  = 2'd3
  } state_t;

  state_t                   state;
  logic                     ready_q;
  logic                     timeout_q;
  logic                     pend_sample;
  logic                     pend_timeout;
  logic                     pend_fs;
  logic signed [ERR_W-1:0]  err_cap;
  logic [CNT_W-1:0]         lock_cnt;

  logic                     sample_ev;
  logic                     timeout_ev;
  logic signed [ERR_W-1:0]  err_new;
  logic signed [ERR_W-1:0]  err_shifted;
  logic [ERR_W-1:0]         err_abs;
  logic                     in_acq_tol;
  logic                     in_lock_tol;
  logic signed [SUM_W-1:0]  to_step;
  logic signed [SUM_W-1:0]  delta;
  logic signed [SUM_W-1:0]  sum;
  logic [CODE_W-1:0]        code_sat;

  assign sample_ev  = pfd_ready & ~ready_q;
  assign timeout_ev = pfd_timeout & ~timeout_q;
  assign err_new    = $signed({1'b0, pfd_diff_1}) - $signed({1'b0, pfd_diff_2});

  // Step size comes from the state before any transition on this edge.
  assign err_shifted = (state == ST_ACQUIRE) ? (err_cap >>> ACQ_SHIFT) : (err_cap >>> TRK_SHIFT);
  assign err_abs     = err_cap[ERR_W-1] ? ERR_W'(-err_cap) : ERR_W'(err_cap);
  assign in_acq_tol  = (32'(err_abs) <= ACQ_TOL);
  assign in_lock_tol = (32'(err_abs) <= LOCK_TOL);

  assign to_step = $signed(SUM_W'(TO_STEP));
  assign delta   = pend_timeout ? (pend_fs ? -to_step : to_step) : SUM_W'(err_shifted);
  assign sum     = $signed({2'b00, dco_code}) + delta;

  // Negative sums clamp to zero, anything above the code range clamps to full scale.
  always_comb begin
    code_sat = sum[CODE_W-1:0];
    if (sum[SUM_W-1]) begin
      code_sat = '0;
    end else if (sum[SUM_W-2:CODE_W] != '0) begin
      code_sat = '1;
    end
  end

  assign loop_state = state;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state        <= ST_IDLE;
      ready_q      <= 1'b0;
      timeout_q    <= 1'b0;
      pend_sample  <= 1'b0;
      pend_timeout <= 1'b0;
      pend_fs      <= 1'b0;
      err_cap      <= '0;
      lock_cnt     <= '0;
      dco_code     <= CODE_W'(CODE_INIT);
      code_valid   <= 1'b0;
      locked       <= 1'b0;
      err_out      <= '0;
    end else begin
      ready_q      <= pfd_ready;
      timeout_q    <= pfd_timeout;
      code_valid   <= 1'b0;
      pend_sample  <= 1'b0;
      pend_timeout <= 1'b0;

      // Capture stage: a timeout pre-empts a coincident sample; IDLE discards both.
      if (enable && state != ST_IDLE) begin
        if (timeout_ev) begin
          pend_timeout <= 1'b1;
          pend_fs      <= pfd_first_second;
        end else if (sample_ev) begin
          pend_sample <= 1'b1;
          err_cap     <= err_new;
        end
      end

      if (!enable) begin
        state    <= ST_IDLE;
        locked   <= 1'b0;
        lock_cnt <= '0;
      end else if (state == ST_IDLE) begin
        state <= ST_ACQUIRE;
      end else if (pend_timeout) begin
        dco_code   <= code_sat;
        code_valid <= 1'b1;
        state      <= ST_ACQUIRE;
        locked     <= 1'b0;
        lock_cnt   <= '0;
      end else if (pend_sample) begin
        dco_code   <= code_sat;
        code_valid <= 1'b1;
        err_out    <= err_cap;
        case (state)
          ST_ACQUIRE: begin
            if (in_acq_tol) begin
              state    <= ST_TRACK;
              lock_cnt <= '0;
            end
          end
          ST_TRACK: begin
            if (!in_acq_tol) begin
              state    <= ST_ACQUIRE;
              lock_cnt <= '0;
            end else if (in_lock_tol) begin
              lock_cnt <= lock_cnt + 1'b1;
              if (lock_cnt == CNT_W'(LOCK_CNT - 1)) begin
                state  <= ST_LOCKED;
                locked <= 1'b1;
              end
            end else begin
              lock_cnt <= '0;
            end
          end
          ST_LOCKED: begin
            if (!in_acq_tol) begin
              state    <= ST_ACQUIRE;
              locked   <= 1'b0;
              lock_cnt <= '0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
